// File: rtl/phy_tx_defs.sv
// Shared constants and state encoding for the phy_tx serializer path.
package phy_tx_defs;

    localparam int unsigned       PHY_DATA_W     = 8;
    localparam logic [7:0]        PHY_COMMA      = 8'hBC;
    localparam int unsigned       PHY_SYNC_COUNT = 4;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_e;

endpackage

// File: rtl/phy_tx_fifo2.sv
// Two-entry FIFO feeding the serializer; exposes head, count and full.
module phy_tx_fifo2 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              head_idx_q, head_idx_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop, tail_idx;

    always_comb begin
        do_push    = push && (count_q != 2'd2);
        do_pop     = pop && (count_q != 2'd0);
        // Tail is head + count modulo 2; only count bit 0 matters when not full.
        tail_idx   = head_idx_q ^ count_q[0];
        mem_d      = mem_q;
        if (do_push) begin
            mem_d[tail_idx] = din;
        end
        head_idx_d = head_idx_q ^ do_pop;
        count_d    = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            head_idx_q <= 1'b0;
            count_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            head_idx_q <= head_idx_d;
            count_q    <= count_d;
        end
    end

    assign head  = mem_q[head_idx_q];
    assign count = count_q;
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/paralelo_serial_tx.sv
// Serializer stage of phy_tx: buffers bytes, shifts them out MSB-first, fills idle slots with commas.
module paralelo_serial_tx
    import phy_tx_defs::*;
#(
    parameter int unsigned       DATA_W     = PHY_DATA_W,
    parameter logic [DATA_W-1:0] COMMA      = PHY_COMMA,
    parameter int unsigned       SYNC_COUNT = PHY_SYNC_COUNT
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid_in0,
    output logic              ready_out0,
    output logic              data_out,
    output logic              active_out
);

    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned SYNC_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DATA_W - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COUNT - 1);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    tx_state_e         state_q, state_d;
    logic              active_q, active_d;

    logic              load, push, pop;
    logic [DATA_W-1:0] fifo_head;
    logic [1:0]        fifo_count;
    logic              fifo_full;

    phy_tx_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk_32f),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (data_in0),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full)
    );

    // No bypass: ready follows the registered count only.
    assign ready_out0 = !fifo_full;
    assign push       = valid_in0 && ready_out0;
    assign load       = (bit_cnt_q == '0);
    assign pop        = load && (state_q == ACTIVE) && (fifo_count != 2'd0);

    always_comb begin
        bit_cnt_d  = load ? CNT_MAX : bit_cnt_q - CNT_W'(1);
        shreg_d    = shreg_q << 1;
        sync_cnt_d = sync_cnt_q;
        state_d    = state_q;
        active_d   = active_q;
        if (load) begin
            shreg_d = pop ? fifo_head : COMMA;
            if (state_q == SYNC) begin
                sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d  = ACTIVE;
                    active_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            shreg_q    <= '0;
            bit_cnt_q  <= CNT_MAX;
            sync_cnt_q <= '0;
            state_q    <= SYNC;
            active_q   <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            state_q    <= state_d;
            active_q   <= active_d;
        end
    end

    assign data_out   = shreg_q[DATA_W-1];
    assign active_out = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: driver queues expected bytes, monitor de-serializes the line.
module tb_paralelo_serial_tx;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_32f   = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] data_in0  = '0;
    logic       valid_in0 = 1'b0;
    logic       ready_out0, data_out, active_out;

    paralelo_serial_tx #(
        .DATA_W     (8),
        .COMMA      (8'hBC),
        .SYNC_COUNT (4)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in0   (data_in0),
        .valid_in0  (valid_in0),
        .ready_out0 (ready_out0),
        .data_out   (data_out),
        .active_out (active_out)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [7:0] b;
        int         slot;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         e;
    logic [7:0] cur = '0;
    int         mon_slot;
    exp_t       mon_h;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, exp, e);
        end
    endtask

    // Edges since the last reset release; load edges fall on multiples of 8.
    always @(posedge clk_32f or posedge reset) begin
        if (reset) e <= 0;
        else       e <= e + 1;
    end

    always @(negedge clk_32f) begin
        if (!reset && e >= 8) begin
            cur = {cur[6:0], data_out};
            if ((e - 8) % 8 == 7) begin
                mon_slot = (e - 7) / 8;
                if (mon_slot <= 4) begin
                    check("preamble_comma", int'(cur), int'(COMMA));
                end else if (cur != COMMA) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h in slot %0d, required comma", cur, mon_slot);
                    end else begin
                        mon_h = sb.pop_front();
                        check("byte_value", int'(cur), int'(mon_h.b));
                        if (mon_h.slot >= 0) check("byte_slot", mon_slot, mon_h.slot);
                    end
                end else if (sb.size() > 0 && sb[0].slot == mon_slot) begin
                    check("missing_byte", int'(cur), int'(sb[0].b));
                end
            end
        end
    end

    task automatic wait_e(input int n);
        while (e < n) @(negedge clk_32f);
    endtask

    task automatic drive(input logic [7:0] b, input logic exp_rdy, input int slot);
        exp_t it;
        check("ready_at_push", int'(ready_out0), int'(exp_rdy));
        data_in0  = b;
        valid_in0 = 1'b1;
        if (ready_out0) begin
            it.b    = b;
            it.slot = slot;
            sb.push_back(it);
        end
        @(negedge clk_32f);
        valid_in0 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        exp_t       it;

        #1;
        check("rst_data_out", int'(data_out), 0);
        check("rst_active", int'(active_out), 0);
        check("rst_ready", int'(ready_out0), 1);
        @(negedge clk_32f);
        reset = 1'b0;

        // Idle preamble
        wait_e(31); check("active_before_4th_load", int'(active_out), 0);
        wait_e(32); check("active_at_4th_load", int'(active_out), 1);
        wait_e(64); check("active_stays", int'(active_out), 1);

        // Bytes pushed during SYNC wait for ACTIVE
        do_reset();
        wait_e(1);
        drive(8'hA5, 1'b1, 5);
        drive(8'h3C, 1'b1, 6);
        drive(8'h77, 1'b0, -1);
        wait_e(39); check("ready_full_in_sync", int'(ready_out0), 0);
        wait_e(40); check("ready_after_first_pop", int'(ready_out0), 1);

        // Back-to-back bytes in ACTIVE
        wait_e(56); drive(8'h01, 1'b1, 8);
        wait_e(64); drive(8'h02, 1'b1, 9);
        wait_e(72); drive(8'hFF, 1'b1, 10);
        wait_e(80); drive(8'h00, 1'b1, 11);

        // Push coincident with a load on an empty FIFO
        wait_e(95); drive(8'h81, 1'b1, 13);

        // Asynchronous reset mid-byte with two buffered bytes
        wait_e(105);
        drive(8'h11, 1'b1, -1);
        drive(8'h22, 1'b1, -1);
        check("ready_full_before_reset", int'(ready_out0), 0);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("async_rst_data_out", int'(data_out), 0);
        check("async_rst_active", int'(active_out), 0);
        check("async_rst_ready", int'(ready_out0), 1);
        @(negedge clk_32f);
        reset = 1'b0;
        wait_e(31); check("re_preamble_active_low", int'(active_out), 0);
        wait_e(48);
        check("re_preamble_active_high", int'(active_out), 1);
        check("no_stale_expected", sb.size(), 0);

        // Random traffic honouring ready
        for (int i = 0; i < 10000; i++) begin
            if (ready_out0 && $urandom_range(0, 99) < 15) begin
                b = 8'($urandom_range(0, 255));
                if (b == COMMA) b = 8'h5A;
                data_in0  = b;
                valid_in0 = 1'b1;
                it.b      = b;
                it.slot   = -1;
                sb.push_back(it);
            end else begin
                valid_in0 = 1'b0;
            end
            @(negedge clk_32f);
        end
        valid_in0 = 1'b0;
        repeat (48) @(negedge clk_32f);
        check("random_drain_empty", sb.size(), 0);
        check("random_active", int'(active_out), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
